// File: rtl/rr_output_port_allocator.sv
// Output-port switch allocator: matrix round-robin arbitration among input ports,
// wormhole lock from head to tail flit, and downstream credit tracking.
module rr_output_port_allocator #(
  parameter int P_ROUTER_ID  = 0,
  parameter int P_CHANNEL_ID = 0,
  parameter int P_NUM_INPUTS = 5,
  parameter int P_CREDITS    = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [P_NUM_INPUTS-1:0] req,
  input  logic [P_NUM_INPUTS-1:0] head,
  input  logic [P_NUM_INPUTS-1:0] tail,
  input  logic                    credit_in,
  output logic [P_NUM_INPUTS-1:0] grant,
  output logic                    flit_valid,
  output logic                    locked,
  output logic [2:0]              owner,
  output logic [3:0]              credit_count,
  output logic                    credit_err
);

  localparam int N = P_NUM_INPUTS;
  localparam logic [3:0] L_MAX_CREDITS = 4'(P_CREDITS);

  if (P_NUM_INPUTS < 2 || P_NUM_INPUTS > 8 || P_CREDITS < 1 || P_CREDITS > 15 ||
      P_ROUTER_ID < 0 || P_CHANNEL_ID < 0) begin : g_paramCheck
    $error("rr_output_port_allocator: parameter out of range");
  end

  // r_prio[i][j]=1 means input i currently beats input j.
  logic [N-1:0][N-1:0] r_prio;
  logic                r_locked;
  logic [2:0]          r_owner;
  logic [3:0]          r_credits;
  logic                r_err;

  logic [N-1:0]        w_eligible;
  logic [N-1:0]        w_grant;
  logic                w_hasCredit;
  logic                w_grantTail;
  logic [2:0]          w_grantIdx;

  always_comb begin
    w_eligible  = req & head;
    w_hasCredit = (r_credits != 4'd0);
    w_grant     = '0;
    if (!RST && w_hasCredit) begin
      if (r_locked) begin
        for (int i = 0; i < N; i++) begin
          if (r_owner == 3'(i)) w_grant[i] = req[i];
        end
      end else begin
        for (int w = 0; w < N; w++) begin
          w_grant[w] = w_eligible[w];
          for (int j = 0; j < N; j++) begin
            if (j != w && w_eligible[j] && !r_prio[w][j]) w_grant[w] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_grantTail = |(w_grant & tail);
    w_grantIdx  = 3'd0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) w_grantIdx = 3'(i);
    end
  end

  // The winner drops to lowest priority: its row clears and its column sets.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_prio[i][j] <= (i < j);
        end
      end
    end else if (!r_locked && flit_valid) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (w_grant[i]) r_prio[i][j] <= 1'b0;
          else if (w_grant[j]) r_prio[i][j] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_locked <= 1'b0;
      r_owner  <= 3'd0;
    end else if (flit_valid) begin
      if (!r_locked) begin
        if (!w_grantTail) begin
          r_locked <= 1'b1;
          r_owner  <= w_grantIdx;
        end
      end else if (w_grantTail) begin
        r_locked <= 1'b0;
        r_owner  <= 3'd0;
      end
    end
  end

  // Returning a credit to a full counter is a downstream protocol error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_credits <= L_MAX_CREDITS;
      r_err     <= 1'b0;
    end else begin
      case ({flit_valid, credit_in})
        2'b10: r_credits <= r_credits - 4'd1;
        2'b01: begin
          if (r_credits == L_MAX_CREDITS) r_err <= 1'b1;
          else r_credits <= r_credits + 4'd1;
        end
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign grant        = w_grant;
  assign flit_valid   = |w_grant;
  assign locked       = r_locked;
  assign owner        = r_owner;
  assign credit_count = r_credits;
  assign credit_err   = r_err;

endmodule

// File: tb/tb_rr_output_port_allocator.sv
// Self-checking bench for rr_output_port_allocator: directed scenarios plus
// randomized traffic against a least-recently-granted list model.
module tb_rr_output_port_allocator;

  localparam int N = 5;
  localparam int C = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] head = '0;
  logic [N-1:0] tail = '0;
  logic         credit_in = 1'b0;
  logic [N-1:0] grant;
  logic         flit_valid;
  logic         locked;
  logic [2:0]   owner;
  logic [3:0]   credit_count;
  logic         credit_err;

  int checks = 0;
  int errors = 0;

  // Model state: order[0] is the input that has waited longest since its last grant.
  int           order[$];
  bit           mLocked;
  int           mOwner;
  int           mCredits;
  bit           mErr;
  logic [N-1:0] expGrant;
  bit           pending;

  rr_output_port_allocator #(
    .P_ROUTER_ID(0), .P_CHANNEL_ID(0), .P_NUM_INPUTS(N), .P_CREDITS(C)
  ) dut (
    .CLK(CLK), .RST(RST), .req(req), .head(head), .tail(tail),
    .credit_in(credit_in), .grant(grant), .flit_valid(flit_valid),
    .locked(locked), .owner(owner), .credit_count(credit_count),
    .credit_err(credit_err)
  );

  always #5 CLK = ~CLK;

  task automatic modelReset();
    order.delete();
    for (int i = 0; i < N; i++) order.push_back(i);
    mLocked  = 0;
    mOwner   = 0;
    mCredits = C;
    mErr     = 0;
    expGrant = '0;
  endtask

  task automatic computeExpect();
    expGrant = '0;
    if (!RST && mCredits > 0) begin
      if (mLocked) expGrant[mOwner] = req[mOwner];
      else begin
        foreach (order[k]) begin
          if (expGrant == '0 && req[order[k]] && head[order[k]]) expGrant[order[k]] = 1'b1;
        end
      end
    end
  endtask

  task automatic modelCommit();
    bit fv;
    int w;
    bit wasLocked;
    fv = (expGrant != '0);
    w = 0;
    for (int i = 0; i < N; i++) if (expGrant[i]) w = i;
    wasLocked = mLocked;
    if (fv && !credit_in) mCredits--;
    else if (!fv && credit_in) begin
      if (mCredits == C) mErr = 1;
      else mCredits++;
    end
    if (!wasLocked && fv) begin
      for (int k = 0; k < order.size(); k++) begin
        if (order[k] == w) begin
          order.delete(k);
          break;
        end
      end
      order.push_back(w);
      if (!tail[w]) begin
        mLocked = 1;
        mOwner  = w;
      end
    end else if (wasLocked && fv && tail[mOwner]) begin
      mLocked = 0;
      mOwner  = 0;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] h,
                               input logic [N-1:0] t, input logic c);
    @(posedge CLK);
    if (pending && !RST) modelCommit();
    pending = 1;
    #1;
    req = r;
    head = h;
    tail = t;
    credit_in = c;
    #3;
    computeExpect();
  endtask

  task automatic doReset();
    RST = 1'b1;
    req = '0;
    head = '0;
    tail = '0;
    credit_in = 1'b0;
    modelReset();
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    pending = 0;
  endtask

  task automatic test_reset();
    req = '1;
    head = '1;
    tail = '1;
    repeat (2) @(posedge CLK);
    #3;
    checks++;
    if (grant !== 5'b0 || flit_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_grant got %b/%b want 00000/0", grant, flit_valid);
    end
    checks++;
    if (credit_count !== 4'(C) || locked !== 1'b0 || owner !== 3'd0 || credit_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state got cc=%0d lk=%b own=%0d err=%b want cc=%0d lk=0 own=0 err=0",
               credit_count, locked, owner, credit_err, C);
    end
    doReset();
  endtask

  task automatic test_rotation();
    logic [N-1:0] want [4];
    want[0] = 5'b00010;
    want[1] = 5'b00100;
    want[2] = 5'b10000;
    want[3] = 5'b00010;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(5'b10110, 5'b10110, 5'b10110, 1'b1);
      checks++;
      if (grant !== want[k] || grant !== expGrant) begin
        errors++;
        $display("[TB] FAIL rotation_%0d got %b want %b (model %b)", k, grant, want[k], expGrant);
      end
      checks++;
      if (credit_count !== 4'(C) || flit_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rotation_cc_%0d got cc=%0d fv=%b want cc=%0d fv=1", k, credit_count, flit_valid, C);
      end
    end
  endtask

  task automatic test_wormhole();
    logic [N-1:0] rv [4];
    logic [N-1:0] hv [4];
    logic [N-1:0] tv [4];
    logic [N-1:0] gv [4];
    logic         lv [4];
    logic [2:0]   ov [4];
    rv = '{5'b01010, 5'b01010, 5'b01010, 5'b00010};
    hv = '{5'b01010, 5'b00010, 5'b00010, 5'b00010};
    tv = '{5'b00010, 5'b00010, 5'b01010, 5'b00010};
    gv = '{5'b01000, 5'b01000, 5'b01000, 5'b00010};
    lv = '{1'b0, 1'b1, 1'b1, 1'b0};
    ov = '{3'd0, 3'd3, 3'd3, 3'd0};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(rv[k], hv[k], tv[k], 1'b1);
      checks++;
      if (grant !== gv[k] || grant !== expGrant) begin
        errors++;
        $display("[TB] FAIL wormhole_grant_%0d got %b want %b (model %b)", k, grant, gv[k], expGrant);
      end
      checks++;
      if (locked !== lv[k] || owner !== ov[k]) begin
        errors++;
        $display("[TB] FAIL wormhole_lock_%0d got lk=%b own=%0d want lk=%b own=%0d", k, locked, owner, lv[k], ov[k]);
      end
    end
  endtask

  task automatic test_credit_exhaust();
    int wantCc;
    logic [N-1:0] wantG;
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(5'b00001, 5'b00001, 5'b00001, (k == 5));
      wantCc = (k < 4) ? C - k : (k == 6) ? 1 : 0;
      wantG  = (k < 4 || k == 6) ? 5'b00001 : 5'b00000;
      checks++;
      if (credit_count !== 4'(wantCc) || credit_count !== 4'(mCredits)) begin
        errors++;
        $display("[TB] FAIL exhaust_cc_%0d got %0d want %0d", k, credit_count, wantCc);
      end
      checks++;
      if (grant !== wantG || grant !== expGrant) begin
        errors++;
        $display("[TB] FAIL exhaust_grant_%0d got %b want %b", k, grant, wantG);
      end
    end
  endtask

  task automatic test_credit_both_and_err();
    int wantCc [6];
    logic wantErr [6];
    logic cv [6];
    wantCc  = '{2, 2, 3, 4, 4, 4};
    wantErr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    cv      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    doReset();
    applyStimulus(5'b00001, 5'b00001, 5'b00001, 1'b0);
    applyStimulus(5'b00001, 5'b00001, 5'b00001, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) applyStimulus(5'b00001, 5'b00001, 5'b00001, 1'b1);
      else applyStimulus('0, '0, '0, cv[k]);
      checks++;
      if (credit_count !== 4'(wantCc[k]) || credit_err !== wantErr[k]) begin
        errors++;
        $display("[TB] FAIL credit_%0d got cc=%0d err=%b want cc=%0d err=%b",
                 k, credit_count, credit_err, wantCc[k], wantErr[k]);
      end
    end
  endtask

  task automatic test_reset_midpacket();
    doReset();
    applyStimulus(5'b00100, 5'b00100, 5'b00000, 1'b0);
    applyStimulus(5'b00100, 5'b00000, 5'b00000, 1'b0);
    applyStimulus(5'b00100, 5'b00000, 5'b00000, 1'b0);
    applyStimulus(5'b00100, 5'b00000, 5'b00000, 1'b0);
    checks++;
    if (locked !== 1'b1 || owner !== 3'd2 || credit_count !== 4'd1 || grant !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL midpkt_pre got lk=%b own=%0d cc=%0d g=%b want lk=1 own=2 cc=1 g=00100",
               locked, owner, credit_count, grant);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (locked !== 1'b0 || owner !== 3'd0 || credit_count !== 4'(C) || grant !== 5'b0) begin
      errors++;
      $display("[TB] FAIL midpkt_rst got lk=%b own=%0d cc=%0d g=%b want lk=0 own=0 cc=%0d g=00000",
               locked, owner, credit_count, grant, C);
    end
    doReset();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(5'b00100, 5'b00000, 5'b00000, 1'b0);
      checks++;
      if (grant !== 5'b0 || grant !== expGrant || locked !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midpkt_body_%0d got g=%b lk=%b want g=00000 lk=0", k, grant, locked);
      end
    end
  endtask

  task automatic test_owner_stall();
    logic [N-1:0] rv [5];
    logic [N-1:0] hv [5];
    logic [N-1:0] tv [5];
    logic [N-1:0] gv [5];
    logic         lv [5];
    rv = '{5'b00001, 5'b00110, 5'b00110, 5'b00111, 5'b00110};
    hv = '{5'b00001, 5'b00110, 5'b00110, 5'b00110, 5'b00110};
    tv = '{5'b00000, 5'b00110, 5'b00110, 5'b00111, 5'b00110};
    gv = '{5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b00010};
    lv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(rv[k], hv[k], tv[k], 1'b0);
      checks++;
      if (grant !== gv[k] || grant !== expGrant || locked !== lv[k]) begin
        errors++;
        $display("[TB] FAIL stall_%0d got g=%b lk=%b want g=%b lk=%b", k, grant, locked, gv[k], lv[k]);
      end
    end
  endtask

  task automatic test_random();
    doReset();
    for (int k = 0; k < 400; k++) begin
      applyStimulus(N'($urandom), N'($urandom), N'($urandom), ($urandom_range(0, 2) == 0));
      checks++;
      if (grant !== expGrant || flit_valid !== (expGrant != '0)) begin
        errors++;
        $display("[TB] FAIL random_grant_%0d got g=%b fv=%b want g=%b", k, grant, flit_valid, expGrant);
      end
      checks++;
      if (locked !== mLocked || owner !== 3'(mOwner) || credit_count !== 4'(mCredits) ||
          credit_err !== mErr) begin
        errors++;
        $display("[TB] FAIL random_state_%0d got lk=%b own=%0d cc=%0d err=%b want lk=%b own=%0d cc=%0d err=%b",
                 k, locked, owner, credit_count, credit_err, mLocked, mOwner, mCredits, mErr);
      end
    end
  endtask

  initial begin
    modelReset();
    pending = 0;
    test_reset();
    test_rotation();
    test_wormhole();
    test_credit_exhaust();
    test_credit_both_and_err();
    test_reset_midpacket();
    test_owner_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
